ddr_dqs_wr_burst_tx: RTL and testbench

- Write-direction DQS/DQ burst generator; the transmit counterpart of the DQS read-capture and preamble-detect buffer.
- Accepts write commands and drives DQS through latency, preamble, toggling data strobe and postamble.
- Serializes one DQ beat per CLKP cycle, so CLKP runs at 2x DQS frequency.
- Sits between the write-data path of the memory controller and the DDR output registers.

---
 rtl/ddr_tx_pkg.sv | 26 ++
 rtl/ddr_dqs_wr_burst_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ddr_dqs_wr_burst_tx.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_tx_pkg.sv
// ---------------------------------------------------------------------------
// ddr_tx_pkg
//   Shared types and constants for the DDR write-direction DQS/DQ burst
//   generator.
//   - tx_state_e : burst sequencer states.
//   - BL4_LAST / BL8_LAST : index of the final beat of a 4- / 8-beat burst.
//   - burst_last() : final beat index for the latched burst-length flag.
// ---------------------------------------------------------------------------
package ddr_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LAT  = 3'd1,
    PRE  = 3'd2,
    DATA = 3'd3,
    POST = 3'd4
  } tx_state_e;

  localparam logic [2:0] BL4_LAST = 3'd3;
  localparam logic [2:0] BL8_LAST = 3'd7;

  function automatic logic [2:0] burst_last(input logic bl8);
    return bl8 ? BL8_LAST : BL4_LAST;
  endfunction

endpackage

// File: rtl/ddr_dqs_wr_burst_tx.sv
// ---------------------------------------------------------------------------
// ddr_dqs_wr_burst_tx
//   Write-direction DQS/DQ burst generator. A write command is accepted,
//   DQS is held off for the write latency, then a preamble, a toggling
//   strobe with one DQ beat per CLKP cycle, and a one-cycle postamble are
//   driven. CLKP runs at twice the DQS rate.
//
// Ports
//   CLKP       : x2 strobe-rate clock, rising edge.
//   RSTB       : asynchronous reset, active-high; aborts any burst at once.
//   cmd_valid  : write command present (held by upstream until accepted).
//   cmd_ready  : command accepted when cmd_valid & cmd_ready.
//   cmd_wl     : write latency in CLKP cycles, sampled at accept only.
//   cmd_bl8    : 1 = 8-beat burst, 0 = 4-beat burst.
//   dat_valid  : beat available on dat_in.
//   dat_ready  : beat on dat_in is consumed at this edge.
//   dat_in     : beat data.
//   dq_o       : registered DQ beat (zero outside DATA and on a missing beat).
//   dq_oe      : DQ output enable.
//   dqs_o      : registered DQS; the DQS_INV polarity swap is folded into
//                this flop so the reset level is DQS_INV.
//   dqs_oe     : DQS output enable.
//   busy       : sequencer not idle.
//   underrun   : sticky, a beat was missing during DATA; cleared by reset.
//
// Every output flop is loaded from the state being entered on the same edge,
// so the output shows the behaviour of the current state. As a consequence a
// DATA beat is captured on the edge that enters (or stays in) DATA, which is
// why dat_ready follows the next state rather than the current one.
// ---------------------------------------------------------------------------
module ddr_dqs_wr_burst_tx
  import ddr_tx_pkg::*;
#(
  parameter int DQ_W    = 8,
  parameter int WL_W    = 4,
  parameter int PRE_CYC = 2,
  parameter bit DQS_INV = 1'b0
) (
  input  logic            CLKP,
  input  logic            RSTB,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [WL_W-1:0] cmd_wl,
  input  logic            cmd_bl8,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [DQ_W-1:0] dat_in,
  output logic [DQ_W-1:0] dq_o,
  output logic            dq_oe,
  output logic            dqs_o,
  output logic            dqs_oe,
  output logic            busy,
  output logic            underrun
);

  localparam int              PRE_W    = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CYC - 1);

  tx_state_e        state_q, state_d;
  logic [WL_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]       beat_cnt_q, beat_cnt_d;
  logic             bl8_q, bl8_d;
  // Set when POST is followed by another burst instead of IDLE.
  logic             pend_q, pend_d;

  logic [DQ_W-1:0]  dq_o_q, dq_o_d;
  logic             dq_oe_q, dq_oe_d;
  logic             dqs_o_q, dqs_o_d;
  logic             dqs_oe_q, dqs_oe_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;

  logic             last_beat;
  logic             accept;
  logic             data_next;

  // Handshake: ready while idle, or on the final beat so a follow-on burst
  // can be chained without a gap.
  always_comb begin
    last_beat = (state_q == DATA) && (beat_cnt_q == burst_last(bl8_q));
    cmd_ready = (state_q == IDLE) || last_beat;
    accept    = cmd_valid & cmd_ready;
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    beat_cnt_d = beat_cnt_q;
    bl8_d      = bl8_q;
    pend_d     = pend_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bl8_d     = cmd_bl8;
          lat_cnt_d = cmd_wl;
          pre_cnt_d = '0;
          state_d   = (cmd_wl == '0) ? PRE : LAT;
        end
      end

      LAT: begin
        lat_cnt_d = lat_cnt_q - WL_W'(1);
        if (lat_cnt_q == WL_W'(1)) begin
          state_d   = PRE;
          pre_cnt_d = '0;
        end
      end

      PRE: begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (pre_cnt_q == PRE_LAST) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end

      DATA: begin
        beat_cnt_d = beat_cnt_q + 3'd1;
        if (last_beat) begin
          if (accept) begin
            bl8_d = cmd_bl8;
            if (cmd_wl == '0) begin
              // Seamless chaining: strobe keeps toggling, no post/preamble.
              state_d    = DATA;
              beat_cnt_d = '0;
            end else begin
              // POST absorbs one latency cycle, so the preamble still starts
              // cmd_wl+1 cycles after the accept edge.
              state_d   = POST;
              pend_d    = 1'b1;
              lat_cnt_d = cmd_wl;
            end
          end else begin
            state_d = POST;
            pend_d  = 1'b0;
          end
        end
      end

      POST: begin
        pend_d = 1'b0;
        if (!pend_q) begin
          state_d = IDLE;
        end else if (lat_cnt_q == WL_W'(1)) begin
          state_d   = PRE;
          pre_cnt_d = '0;
        end else begin
          state_d   = LAT;
          lat_cnt_d = lat_cnt_q - WL_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register inputs, all derived from the state being entered.
  always_comb begin
    data_next  = (state_d == DATA);
    dat_ready  = data_next;
    busy_d     = (state_d != IDLE);
    dqs_oe_d   = (state_d == PRE) || (state_d == DATA) || (state_d == POST);
    dq_oe_d    = data_next;
    // Even beats drive DQS high, so the first beat is a rising strobe.
    dqs_o_d    = (data_next && !beat_cnt_d[0]) ^ DQS_INV;
    dq_o_d     = (data_next && dat_valid) ? dat_in : '0;
    // The burst never stalls: a missing beat is sent as zero and flagged.
    underrun_d = underrun_q | (data_next & ~dat_valid);
  end

  always_ff @(posedge CLKP or posedge RSTB) begin
    if (RSTB) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      pre_cnt_q  <= '0;
      beat_cnt_q <= '0;
      bl8_q      <= 1'b0;
      pend_q     <= 1'b0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      dqs_o_q    <= DQS_INV;
      dqs_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      bl8_q      <= bl8_d;
      pend_q     <= pend_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      dqs_o_q    <= dqs_o_d;
      dqs_oe_q   <= dqs_oe_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign dq_o     = dq_o_q;
  assign dq_oe    = dq_oe_q;
  assign dqs_o    = dqs_o_q;
  assign dqs_oe   = dqs_oe_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ddr_dqs_wr_burst_tx.sv
// ---------------------------------------------------------------------------
// tb_ddr_dqs_wr_burst_tx
//   Self-checking bench for ddr_dqs_wr_burst_tx. A fixed vector table covers
//   a plain wl=0 BL8 burst; directed and random traffic is then checked
//   against a timeline model that schedules each accepted burst as a list of
//   per-cycle phases (latency, preamble, beats, postamble).
// ---------------------------------------------------------------------------
module tb_ddr_dqs_wr_burst_tx;

  localparam int DQ_W    = 8;
  localparam int WL_W    = 4;
  localparam int PRE_CYC = 2;

  logic            CLKP = 1'b0;
  logic            RSTB;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [WL_W-1:0] cmd_wl;
  logic            cmd_bl8;
  logic            dat_valid;
  logic            dat_ready;
  logic [DQ_W-1:0] dat_in;
  logic [DQ_W-1:0] dq_o;
  logic            dq_oe;
  logic            dqs_o;
  logic            dqs_oe;
  logic            busy;
  logic            underrun;

  ddr_dqs_wr_burst_tx #(
    .DQ_W    (DQ_W),
    .WL_W    (WL_W),
    .PRE_CYC (PRE_CYC),
    .DQS_INV (1'b0)
  ) dut (
    .CLKP      (CLKP),
    .RSTB      (RSTB),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wl    (cmd_wl),
    .cmd_bl8   (cmd_bl8),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .dat_in    (dat_in),
    .dq_o      (dq_o),
    .dq_oe     (dq_oe),
    .dqs_o     (dqs_o),
    .dqs_oe    (dqs_oe),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 CLKP = ~CLKP;

  int checks = 0;
  int errors = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic       cv;
    logic [3:0] wl;
    logic       bl8;
    logic       dv;
    logic [7:0] din;
    logic       e_busy;
    logic       e_dqs_oe;
    logic       e_dqs;
    logic       e_dq_oe;
    logic [7:0] e_dq;
    logic       e_under;
    logic       e_cmd_rdy;
    logic       e_dat_rdy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic cv, input logic [3:0] wl, input logic bl8,
                              input logic dv, input logic [7:0] din,
                              input logic b, input logic so, input logic s,
                              input logic qo, input logic [7:0] q, input logic u,
                              input logic cr, input logic dr);
    vec_t v;
    v.cv = cv; v.wl = wl; v.bl8 = bl8; v.dv = dv; v.din = din;
    v.e_busy = b; v.e_dqs_oe = so; v.e_dqs = s; v.e_dq_oe = qo; v.e_dq = q;
    v.e_under = u; v.e_cmd_rdy = cr; v.e_dat_rdy = dr;
    return v;
  endfunction

  // ---------------- timeline model ----------------
  typedef struct {
    logic [WL_W-1:0] wl;
    logic            bl8;
  } cmd_t;

  cmd_t            cmd_q[$];
  int              ph[64];   // 0 idle, 1 latency, 2 preamble, 3 beat, 4 postamble
  int              bt[64];   // beat index within its burst
  int              cyc;
  int              last_busy;
  int              last_beat;
  logic            under_e;
  logic            prev_dv;
  logic [DQ_W-1:0] prev_din;
  int              drop_beat = -1;
  int              dv_pct = 100;
  int              cur_p, cur_bt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ph[i]) begin
      ph[i] = 0;
      bt[i] = 0;
    end
    last_busy = -1;
    last_beat = -1;
    under_e   = 1'b0;
    prev_dv   = 1'b0;
    prev_din  = '0;
    cmd_q.delete();
  endtask

  task automatic push_cmd(input int wl, input bit bl8);
    cmd_t x;
    x.wl  = WL_W'(wl);
    x.bl8 = bl8;
    cmd_q.push_back(x);
  endtask

  // Schedule a burst accepted in cycle t.
  task automatic fill(input int t, input int wl, input bit bl8);
    int  n, ds;
    bit  from_data;
    n         = bl8 ? 8 : 4;
    from_data = (t == last_beat);
    if (from_data && wl == 0) begin
      ds = t + 1;
    end else begin
      for (int k = t + 1; k <= t + wl; k++) ph[k & 63] = 1;
      if (from_data) ph[(t + 1) & 63] = 4;
      for (int k = 0; k < PRE_CYC; k++) ph[(t + wl + 1 + k) & 63] = 2;
      ds = t + wl + 1 + PRE_CYC;
    end
    for (int k = 0; k < n; k++) begin
      ph[(ds + k) & 63] = 3;
      bt[(ds + k) & 63] = k;
    end
    ph[(ds + n) & 63] = 4;
    last_beat = ds + n - 1;
    last_busy = ds + n;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check handshakes.
  task automatic step();
    int p, b, c, n1;
    bit rdy_e, nb;
    @(posedge CLKP);
    #1;
    cyc++;
    c     = cyc & 63;
    p     = ph[c];
    b     = bt[c];
    cur_p = p;
    cur_bt = b;
    if (p == 3 && !prev_dv) under_e = 1'b1;
    chk("busy",     int'(busy),     int'(p != 0));
    chk("dqs_oe",   int'(dqs_oe),   int'(p >= 2));
    chk("dq_oe",    int'(dq_oe),    int'(p == 3));
    chk("dqs_o",    int'(dqs_o),    int'(p == 3 && (b % 2) == 0));
    chk("dq_o",     int'(dq_o),     (p == 3 && prev_dv) ? int'(prev_din) : 0);
    chk("underrun", int'(underrun), int'(under_e));
    ph[c] = 0;
    bt[c] = 0;

    if (cmd_q.size() > 0) begin
      cmd_valid = 1'b1;
      cmd_wl    = cmd_q[0].wl;
      cmd_bl8   = cmd_q[0].bl8;
    end else begin
      cmd_valid = 1'b0;
      cmd_wl    = WL_W'($urandom);
      cmd_bl8   = 1'($urandom);
    end
    dat_in = DQ_W'($urandom);

    rdy_e = (cyc > last_busy) || (cyc == last_beat);
    if (cmd_valid && rdy_e) begin
      fill(cyc, int'(cmd_wl), cmd_bl8);
      void'(cmd_q.pop_front());
    end
    n1 = (cyc + 1) & 63;
    nb = (ph[n1] == 3);
    if (nb && bt[n1] == drop_beat) dat_valid = 1'b0;
    else dat_valid = ($urandom_range(0, 99) < dv_pct);
    #1;
    chk("cmd_ready", int'(cmd_ready), int'(rdy_e));
    chk("dat_ready", int'(dat_ready), int'(nb));
    prev_dv  = dat_valid;
    prev_din = dat_in;
  endtask

  initial begin
    bit found;

    // wl=0 BL8 burst of 0x10..0x17, one row per cycle.
    tbl[0]  = mk(1'b1, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 4'd0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 3; k <= 9; k++)
      tbl[k] = mk(1'b0, 4'd0, 1'b0, 1'b1, 8'(8'h11 + k - 3), 1'b1, 1'b1,
                  1'((k - 3) % 2 == 0), 1'b1, 8'(8'h10 + k - 3), 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    RSTB      = 1'b1;
    cmd_valid = 1'b0;
    cmd_wl    = '0;
    cmd_bl8   = 1'b0;
    dat_valid = 1'b0;
    dat_in    = '0;
    cyc       = 0;
    model_reset();

    repeat (3) @(posedge CLKP);
    #1;
    chk("rst_busy",     int'(busy),     0);
    chk("rst_dqs_oe",   int'(dqs_oe),   0);
    chk("rst_dqs_o",    int'(dqs_o),    0);
    chk("rst_dq_oe",    int'(dq_oe),    0);
    chk("rst_dq_o",     int'(dq_o),     0);
    chk("rst_underrun", int'(underrun), 0);
    @(negedge CLKP);
    RSTB = 1'b0;

    for (int r = 0; r < 13; r++) begin
      @(posedge CLKP);
      #1;
      cyc++;
      chk("t_busy",     int'(busy),     int'(tbl[r].e_busy));
      chk("t_dqs_oe",   int'(dqs_oe),   int'(tbl[r].e_dqs_oe));
      chk("t_dqs_o",    int'(dqs_o),    int'(tbl[r].e_dqs));
      chk("t_dq_oe",    int'(dq_oe),    int'(tbl[r].e_dq_oe));
      chk("t_dq_o",     int'(dq_o),     int'(tbl[r].e_dq));
      chk("t_underrun", int'(underrun), int'(tbl[r].e_under));
      cmd_valid = tbl[r].cv;
      cmd_wl    = tbl[r].wl;
      cmd_bl8   = tbl[r].bl8;
      dat_valid = tbl[r].dv;
      dat_in    = tbl[r].din;
      #1;
      chk("t_cmd_ready", int'(cmd_ready), int'(tbl[r].e_cmd_rdy));
      chk("t_dat_ready", int'(dat_ready), int'(tbl[r].e_dat_rdy));
    end
    model_reset();

    // Long latency, BL4.
    push_cmd(5, 1'b0);
    repeat (16) step();
    // Back-to-back BL4, second seamless.
    push_cmd(0, 1'b0);
    push_cmd(0, 1'b0);
    repeat (16) step();
    // Back-to-back, second with wl=2 (POST, LAT, PRE).
    push_cmd(0, 1'b0);
    push_cmd(2, 1'b0);
    repeat (20) step();
    // Missing beat 2 of BL8.
    drop_beat = 2;
    push_cmd(0, 1'b1);
    repeat (16) step();
    drop_beat = -1;
    chk("t5_underrun_sticky", int'(underrun), 1);

    // Async reset during beat 3.
    push_cmd(0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cur_p == 3 && cur_bt == 3) found = 1'b1;
    end
    chk("t6_reach_beat3", int'(found), 1);
    #1;
    RSTB      = 1'b1;
    cmd_valid = 1'b0;
    dat_valid = 1'b0;
    #1;
    chk("t6_dqs_oe",   int'(dqs_oe),   0);
    chk("t6_dq_oe",    int'(dq_oe),    0);
    chk("t6_busy",     int'(busy),     0);
    chk("t6_dqs_o",    int'(dqs_o),    0);
    chk("t6_underrun", int'(underrun), 0);
    @(negedge CLKP);
    RSTB = 1'b0;
    model_reset();
    push_cmd(0, 1'b0);
    repeat (12) step();

    // Random traffic; commands queued whenever the queue runs dry.
    for (int i = 0; i < 1500; i++) begin
      if (cmd_q.size() == 0 && $urandom_range(0, 2) == 0)
        push_cmd(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 2)),
                 1'($urandom));
      dv_pct = (i < 750) ? 100 : 93;
      step();
    end
    dv_pct = 100;
    for (int i = 0; i < 80 && (cmd_q.size() != 0 || cyc <= last_busy); i++) step();
    chk("drain_queue", cmd_q.size(), 0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
